frame_sequencer: RTL and testbench

Sequencer for the audio frame timing path. Consumes the 240 Hz frame enable and produces the quarter-frame (envelope/linear-counter) and half-frame (length-counter/sweep) clock pulses for the channel units, plus the frame interrupt flag. A CPU-side register write selects 4-step or 5-step mode, sets the IRQ inhibit, and restarts the sequence.

---
 rtl/frame_sequencer.sv | 122 ++++++++++++
 tb/tb_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Audio frame sequencer: divides the 240 Hz frame enable into quarter/half-frame clock pulses and the frame IRQ.
// Optional feature macro FRAME_IRQ_EN builds the IRQ flag; undefined ties frame_irq to 0.
module frame_sequencer #(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       cfg_we,
    input  logic       cfg_mode,
    input  logic       cfg_irq_inhibit,
    input  logic       status_rd,
    output logic       quarter_frame,
    output logic       half_frame,
    output logic       frame_irq,
    output logic [2:0] step
);

    localparam logic [3:0] DIV_LAST = 4'(TICK_DIV - 1);

    logic       r_mode;
    logic       r_inhibit;
    logic [2:0] r_step;
    logic [3:0] r_div;
    logic       r_quarter;
    logic       r_half;

    logic       w_modeNext;
    logic       w_inhibitNext;
    logic [2:0] w_stepNext;
    logic [3:0] w_divNext;
    logic       w_quarterNext;
    logic       w_halfNext;
    logic       w_irqSet;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode    <= 1'b0;
            r_inhibit <= 1'b0;
            r_step    <= 3'd0;
            r_div     <= 4'd0;
            r_quarter <= 1'b0;
            r_half    <= 1'b0;
        end else begin
            r_mode    <= w_modeNext;
            r_inhibit <= w_inhibitNext;
            r_step    <= w_stepNext;
            r_div     <= w_divNext;
            r_quarter <= w_quarterNext;
            r_half    <= w_halfNext;
        end
    end

    // A config write takes priority over a coincident tick, which is dropped without advancing the prescaler.
    always_comb begin
        w_modeNext    = r_mode;
        w_inhibitNext = r_inhibit;
        w_stepNext    = r_step;
        w_divNext     = r_div;
        w_quarterNext = 1'b0;
        w_halfNext    = 1'b0;
        w_irqSet      = 1'b0;
        if (cfg_we) begin
            w_modeNext    = cfg_mode;
            w_inhibitNext = cfg_irq_inhibit;
            w_stepNext    = 3'd0;
            w_divNext     = 4'd0;
            w_quarterNext = cfg_mode;
            w_halfNext    = cfg_mode;
        end else if (tick) begin
            if (r_div == DIV_LAST) begin
                w_divNext = 4'd0;
                if (!r_mode) begin
                    if (r_step > 3'd3) begin
                        w_stepNext = 3'd0;
                    end else begin
                        w_quarterNext = 1'b1;
                        w_halfNext    = r_step[0];
                        w_irqSet      = (r_step == 3'd3) && !r_inhibit;
                        w_stepNext    = (r_step == 3'd3) ? 3'd0 : r_step + 3'd1;
                    end
                end else begin
                    if (r_step > 3'd4) begin
                        w_stepNext = 3'd0;
                    end else begin
                        w_quarterNext = (r_step != 3'd3);
                        w_halfNext    = (r_step == 3'd1) || (r_step == 3'd4);
                        w_stepNext    = (r_step == 3'd4) ? 3'd0 : r_step + 3'd1;
                    end
                end
            end else begin
                w_divNext = r_div + 4'd1;
            end
        end
    end

`ifdef FRAME_IRQ_EN
    logic r_irq;

    // Setting the flag beats any clear arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else if (w_irqSet) begin
            r_irq <= 1'b1;
        end else if ((cfg_we && cfg_irq_inhibit) || status_rd) begin
            r_irq <= 1'b0;
        end
    end

    assign frame_irq = r_irq;
`else
    logic w_unused;
    assign w_unused  = w_irqSet | status_rd;
    assign frame_irq = 1'b0;
`endif

    assign quarter_frame = r_quarter;
    assign half_frame    = r_half;
    assign step          = r_step;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed self-checking bench for frame_sequencer; one DUT at TICK_DIV=1, one at TICK_DIV=3.
// Expected IRQ values follow whether FRAME_IRQ_EN is defined for the build.
module tb_frame_sequencer;

`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic       clk;
    logic       aRst, aTick, aCfgWe, aCfgMode, aCfgInh, aStatusRd;
    logic       aQuarter, aHalf, aIrq;
    logic [2:0] aStep;
    logic       bRst, bTick, bCfgWe, bCfgMode, bCfgInh, bStatusRd;
    logic       bQuarter, bHalf, bIrq;
    logic [2:0] bStep;

    int checks = 0;
    int errors = 0;

    wire [5:0] aObs = {aQuarter, aHalf, aIrq, aStep};
    wire [5:0] bObs = {bQuarter, bHalf, bIrq, bStep};

    frame_sequencer #(.TICK_DIV(1)) dutA (
        .clk(clk), .rst(aRst), .tick(aTick), .cfg_we(aCfgWe), .cfg_mode(aCfgMode),
        .cfg_irq_inhibit(aCfgInh), .status_rd(aStatusRd),
        .quarter_frame(aQuarter), .half_frame(aHalf), .frame_irq(aIrq), .step(aStep)
    );

    frame_sequencer #(.TICK_DIV(3)) dutB (
        .clk(clk), .rst(bRst), .tick(bTick), .cfg_we(bCfgWe), .cfg_mode(bCfgMode),
        .cfg_irq_inhibit(bCfgInh), .status_rd(bStatusRd),
        .quarter_frame(bQuarter), .half_frame(bHalf), .frame_irq(bIrq), .step(bStep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected {quarter, half, irq, step} vector.
    function automatic logic [5:0] ev(input bit q, input bit h, input bit irq, input logic [2:0] s);
        return {q, h, irq, s};
    endfunction

    // One clock with the given strobes on dutA, then sample 1 time unit after the edge.
    task automatic driveA(input bit tk, input bit we, input bit md, input bit inh, input bit rd);
        aTick = tk; aCfgWe = we; aCfgMode = md; aCfgInh = inh; aStatusRd = rd;
        @(posedge clk);
        #1;
        aTick = 1'b0; aCfgWe = 1'b0; aCfgMode = 1'b0; aCfgInh = 1'b0; aStatusRd = 1'b0;
    endtask

    task automatic driveB(input bit tk);
        bTick = tk;
        @(posedge clk);
        #1;
        bTick = 1'b0;
    endtask

    task automatic test_reset;
        aRst = 1'b1; bRst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        aRst = 1'b0; bRst = 1'b0;
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL reset_a got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
        checks++;
        if (bObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL reset_b got %b exp %b", bObs, ev(0, 0, 0, 0));
        end
    endtask

    task automatic test_four_step;
        logic [5:0] exp;
        for (int i = 0; i < 4; i++) begin
            driveA(1, 0, 0, 0, 0);
            exp = ev(1, i[0], (i == 3) & IRQ_EN, 3'((i + 1) % 4));
            checks++;
            if (aObs !== exp) begin
                errors++; $display("[TB] FAIL four_step[%0d] got %b exp %b", i, aObs, exp);
            end
            driveA(0, 0, 0, 0, 0);
            exp = ev(0, 0, (i == 3) & IRQ_EN, 3'((i + 1) % 4));
            checks++;
            if (aObs !== exp) begin
                errors++; $display("[TB] FAIL four_step_idle[%0d] got %b exp %b", i, aObs, exp);
            end
        end
    endtask

    task automatic test_status_rd;
        driveA(0, 0, 0, 0, 1);
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL status_clear got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
        repeat (3) driveA(1, 0, 0, 0, 0);
        driveA(1, 0, 0, 0, 1);
        checks++;
        if (aObs !== ev(1, 1, IRQ_EN, 0)) begin
            errors++; $display("[TB] FAIL status_vs_set got %b exp %b", aObs, ev(1, 1, IRQ_EN, 0));
        end
        driveA(0, 0, 0, 0, 1);
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL status_clear2 got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
    endtask

    task automatic test_five_step;
        logic [4:0] qTab = 5'b10111;
        logic [4:0] hTab = 5'b10010;
        logic [5:0] exp;
        driveA(0, 1, 1, 0, 0);
        checks++;
        if (aObs !== ev(1, 1, 0, 0)) begin
            errors++; $display("[TB] FAIL five_cfg got %b exp %b", aObs, ev(1, 1, 0, 0));
        end
        for (int i = 0; i < 5; i++) begin
            driveA(1, 0, 0, 0, 0);
            exp = ev(qTab[i], hTab[i], 0, 3'((i + 1) % 5));
            checks++;
            if (aObs !== exp) begin
                errors++; $display("[TB] FAIL five_step[%0d] got %b exp %b", i, aObs, exp);
            end
        end
    endtask

    task automatic test_inhibit;
        driveA(0, 1, 0, 0, 0);
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL inh_cfg4 got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
        repeat (4) driveA(1, 0, 0, 0, 0);
        checks++;
        if (aObs !== ev(1, 1, IRQ_EN, 0)) begin
            errors++; $display("[TB] FAIL inh_irq_set got %b exp %b", aObs, ev(1, 1, IRQ_EN, 0));
        end
        driveA(0, 1, 0, 1, 0);
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL inh_clear got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
        repeat (4) driveA(1, 0, 0, 0, 0);
        checks++;
        if (aObs !== ev(1, 1, 0, 0)) begin
            errors++; $display("[TB] FAIL inh_no_irq got %b exp %b", aObs, ev(1, 1, 0, 0));
        end
        repeat (2) driveA(1, 0, 0, 0, 0);
        driveA(1, 1, 0, 1, 0);
        checks++;
        if (aObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL cfg_with_tick got %b exp %b", aObs, ev(0, 0, 0, 0));
        end
        driveA(1, 0, 0, 0, 0);
        checks++;
        if (aObs !== ev(1, 0, 0, 1)) begin
            errors++; $display("[TB] FAIL after_cfg_tick got %b exp %b", aObs, ev(1, 0, 0, 1));
        end
    endtask

    task automatic test_back_to_back;
        logic [5:0] exp;
        driveA(0, 1, 0, 0, 0);
        aTick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            exp = ev(1, i[0], (i == 3) & IRQ_EN, 3'((i + 1) % 4));
            checks++;
            if (aObs !== exp) begin
                errors++; $display("[TB] FAIL b2b[%0d] got %b exp %b", i, aObs, exp);
            end
        end
        aTick = 1'b0;
        driveA(0, 1, 1, 0, 0);
        checks++;
        if (aObs !== ev(1, 1, IRQ_EN, 0)) begin
            errors++; $display("[TB] FAIL cfg_keeps_irq got %b exp %b", aObs, ev(1, 1, IRQ_EN, 0));
        end
    endtask

    task automatic test_tick_div;
        logic [5:0] expTab [6];
        expTab = '{ev(0, 0, 0, 0), ev(0, 0, 0, 0), ev(1, 0, 0, 1),
                   ev(0, 0, 0, 1), ev(0, 0, 0, 1), ev(1, 1, 0, 2)};
        for (int i = 0; i < 6; i++) begin
            driveB(1);
            checks++;
            if (bObs !== expTab[i]) begin
                errors++; $display("[TB] FAIL div3[%0d] got %b exp %b", i, bObs, expTab[i]);
            end
        end
        bRst = 1'b1;
        #1;
        checks++;
        if (bObs !== ev(0, 0, 0, 0)) begin
            errors++; $display("[TB] FAIL mid_reset got %b exp %b", bObs, ev(0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        bRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            driveB(1);
            checks++;
            if (bObs !== expTab[i]) begin
                errors++; $display("[TB] FAIL post_reset[%0d] got %b exp %b", i, bObs, expTab[i]);
            end
        end
    endtask

    initial begin
        aRst = 1'b1; aTick = 1'b0; aCfgWe = 1'b0; aCfgMode = 1'b0; aCfgInh = 1'b0; aStatusRd = 1'b0;
        bRst = 1'b1; bTick = 1'b0; bCfgWe = 1'b0; bCfgMode = 1'b0; bCfgInh = 1'b0; bStatusRd = 1'b0;
        $display("[TB] frame_sequencer bench, IRQ_EN=%0d", IRQ_EN);
        test_reset;
        test_four_step;
        test_status_rd;
        test_five_step;
        test_inhibit;
        test_back_to_back;
        test_tick_div;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
